// File: rtl/dma_pcie_cq_rr_arb.sv
// Packet-level round-robin merge of NUM_SRC CQ AXIS streams onto one stream.
// A grant lasts a whole TLP; a 2-entry skid decouples downstream tready from the sources.
module dma_pcie_cq_rr_arb #(
    parameter int NUM_SRC      = 2,
    parameter int DATA_WIDTH   = 512,
    parameter int USER_WIDTH   = 183,
    parameter int TREADY_WIDTH = 22,
    localparam int KEEP_WIDTH  = DATA_WIDTH / 32,
    localparam int GRANT_WIDTH = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                               user_clk,
    input  logic                               user_reset_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]      s_tdata,
    input  logic [NUM_SRC*USER_WIDTH-1:0]      s_tuser,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0]      s_tkeep,
    input  logic [NUM_SRC-1:0]                 s_tlast,
    input  logic [NUM_SRC-1:0]                 s_tvalid,
    output logic [NUM_SRC*TREADY_WIDTH-1:0]    s_tready,
    output logic [DATA_WIDTH-1:0]              m_tdata,
    output logic [USER_WIDTH-1:0]              m_tuser,
    output logic [KEEP_WIDTH-1:0]              m_tkeep,
    output logic                               m_tlast,
    output logic                               m_tvalid,
    input  logic [TREADY_WIDTH-1:0]            m_tready,
    output logic                               sts_busy,
    output logic [GRANT_WIDTH-1:0]             sts_grant
);

    localparam int BEAT_WIDTH = DATA_WIDTH + USER_WIDTH + KEEP_WIDTH + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    logic [GRANT_WIDTH-1:0] r_grant;
    logic [GRANT_WIDTH-1:0] r_rr_ptr;
    logic [1:0]             r_count;
    logic                   r_not_full;
    logic [BEAT_WIDTH-1:0]  r_buf0;
    logic [BEAT_WIDTH-1:0]  r_buf1;

    int                     w_sel;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_tlast_acc;
    logic [BEAT_WIDTH-1:0]  w_in;
    logic [1:0]             w_count_nxt;
    logic [NUM_SRC-1:0]     w_arb_req;
    logic                   w_hit;
    logic [GRANT_WIDTH-1:0] w_win;
    logic [GRANT_WIDTH-1:0] w_win_nxt;

    assign w_sel       = int'(r_grant);
    assign w_push      = (r_state == ST_BUSY) && r_not_full && s_tvalid[w_sel];
    assign w_pop       = (r_count != 2'd0) && m_tready[0];
    assign w_tlast_acc = w_push && s_tlast[w_sel];
    assign w_in        = {s_tlast[w_sel],
                          s_tkeep[w_sel*KEEP_WIDTH +: KEEP_WIDTH],
                          s_tuser[w_sel*USER_WIDTH +: USER_WIDTH],
                          s_tdata[w_sel*DATA_WIDTH +: DATA_WIDTH]};

    // Round-robin search from r_rr_ptr; the current owner is masked out while BUSY.
    always_comb begin
        int idx;
        idx       = 0;
        w_arb_req = s_tvalid;
        if (r_state == ST_BUSY) begin
            w_arb_req[w_sel] = 1'b0;
        end else begin
            w_arb_req = s_tvalid;
        end
        w_hit = 1'b0;
        w_win = r_rr_ptr;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx   = int'(r_rr_ptr) + k;
            idx   = (idx >= NUM_SRC) ? idx - NUM_SRC : idx;
            w_hit = w_hit | w_arb_req[idx];
            w_win = w_arb_req[idx] ? GRANT_WIDTH'(idx) : w_win;
        end
        w_win_nxt = (w_win == GRANT_WIDTH'(NUM_SRC - 1)) ? '0 : w_win + 1'b1;
    end

    // Grant FSM: IDLE arbitrates without data, BUSY re-arbitrates on the accepted tlast.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_state  <= ST_BUSY;
                        r_grant  <= w_win;
                        r_rr_ptr <= w_win_nxt;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (w_tlast_acc && w_hit) begin
                        r_grant  <= w_win;
                        r_rr_ptr <= w_win_nxt;
                    end else if (w_tlast_acc) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_BUSY;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Skid occupancy after this cycle's push/pop.
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Two-entry skid: r_buf0 is the head driving m_*, r_buf1 holds the overflow beat.
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            r_count    <= 2'd0;
            r_not_full <= 1'b1;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_not_full <= (w_count_nxt < 2'd2);
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf0 <= w_in;
                    end else begin
                        r_buf1 <= w_in;
                    end
                end
                2'b01: r_buf0 <= r_buf1;
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf0 <= w_in;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_in;
                    end
                end
                default: r_buf0 <= r_buf0;
            endcase
        end
    end

    // Per-source tready, replicated across all TREADY_WIDTH bits of a source.
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_tready[i*TREADY_WIDTH +: TREADY_WIDTH] =
                {TREADY_WIDTH{(r_state == ST_BUSY) && r_not_full && (r_grant == GRANT_WIDTH'(i))}};
        end
    end

    assign {m_tlast, m_tkeep, m_tuser, m_tdata} = r_buf0;
    assign m_tvalid  = (r_count != 2'd0);
    assign sts_busy  = (r_state == ST_BUSY);
    assign sts_grant = r_grant;

endmodule
